histogram_ctrl: RTL and testbench
=================================

Name: histogram_ctrl

Overview:
Sequencer for the histogram datapath (bin memory of MAX_NUMBER+1 counters, SIZE bits each). One run, triggered by start, has three phases:
- clear every bin;
- accept exactly n_samples input samples over a valid/ready stream and issue one bin increment per sample;
- read every bin out over a valid/ready result stream.
Sits between the sample source, the histogram memory and the result consumer, and is the only master of the memory's clear/increment/read controls.

Parameters:
SIZE, 7, bin counter width (width of hist_rdata and r_count).
MAX_NUMBER, 127, highest legal sample value; bins 0..MAX_NUMBER. AW = $clog2(MAX_NUMBER+1) (localparam).
CNT_W, 16, width of the sample-count register.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  reset, synchronous, active-low (0 = reset at the CLK edge).
start  in  1  run request; sampled only in IDLE.
n_samples  in  CNT_W  samples per run; latched on accepted start.
s_valid  in  1  input sample valid.
s_ready  out  1  controller accepts sample.
s_data  in  AW  sample value.
hist_clr  out  1  zero bin hist_addr this cycle.
hist_inc  out  1  increment bin hist_addr this cycle.
hist_rd  out  1  read bin hist_addr; data on hist_rdata the next cycle.
hist_addr  out  AW  bin address.
hist_rdata  in  SIZE  bin read data, 1-cycle latency.
r_valid  out  1  result valid.
r_ready  in  1  consumer accepts result.
r_bin  out  AW  bin index of result.
r_count  out  SIZE  bin count of result.
busy  out  1  state != IDLE.
done  out  1  one-cycle pulse at end of run.
oor  out  1  sticky: an out-of-range sample was seen this run.

Behaviour:
- Reset (RST=0 at edge): state IDLE; all counters 0; r_bin, r_count 0; oor 0. All outputs 0, including s_ready, r_valid, hist_*, busy and done. Reset mid-run abandons the run with no done pulse.
- States: IDLE, CLEAR, ACCUM, RD_REQ, RD_WAIT, RD_OUT, DONE. busy, s_ready and done are decoded from the registered state.
- IDLE: if start=1, latch n_samples, clear oor and bin pointer, go to CLEAR next cycle.
- CLEAR: hist_clr=1 with hist_addr = pointer. Pointer runs 0..MAX_NUMBER, one per cycle, so the phase lasts exactly MAX_NUMBER+1 cycles. After the last bin, reset the pointer and sample count, then go to ACCUM, or to RD_REQ if the latched n_samples = 0.
- ACCUM:
  - s_ready=1. A sample transfers when s_valid & s_ready.
  - hist_inc = s_valid & (s_data <= MAX_NUMBER), combinational; hist_addr = s_data.
  - Out-of-range sample (s_data > MAX_NUMBER): consumed and counted, no increment, oor set.
  - After transfer number n_samples, go to RD_REQ with s_ready=0 from the next cycle. At most 1 sample per cycle.
- RD_REQ: hist_rd=1, hist_addr = pointer; next state RD_WAIT.
- RD_WAIT: capture hist_rdata into r_count and the pointer into r_bin; next state RD_OUT.
- RD_OUT:
  - r_valid=1; r_bin and r_count held stable until r_ready=1.
  - On transfer: if pointer == MAX_NUMBER go to DONE, else pointer+1 and go to RD_REQ.
  - Fastest result rate is 1 result per 3 cycles.
- DONE: done=1 for exactly one cycle; then IDLE.
- start while busy is ignored (not queued). n_samples changes after latch have no effect.
- oor holds its value from the end of a run until the next accepted start.
- hist_clr, hist_inc and hist_rd are mutually exclusive. hist_addr = 0 when none of them is asserted.
- Sample counter compares against the full CNT_W value; n_samples = 2^CNT_W-1 must work without wrap.

Test Plan:
- Reset: hold RST=0 for 3 cycles while start=1 -> busy=0, s_ready=0, r_valid=0, done=0, oor=0; stays IDLE.
- Clear sweep: start with n_samples=0 -> hist_clr=1 for exactly 128 consecutive cycles, hist_addr 0..127; then readout of 128 results, r_bin 0..127, all r_count=0; one done pulse.
- Accumulate: n_samples=5, samples 3,3,10,127,3 with s_valid gaps -> hist_inc on exactly 5 cycles; readout gives bin3=3, bin10=1, bin127=1, others 0; oor=0.
- Out of range (MAX_NUMBER=99): n_samples=3, samples 5,120,5 -> 3 samples accepted, 2 increments; bin5=2; oor=1 after run and until the next start.
- Backpressure: during readout hold r_ready=0 for 10 cycles on bin 10 -> r_valid stays 1, r_bin=10 and r_count stable; no hist_rd issued; resumes on r_ready=1.
- Start while busy and mid-run reset: pulse start in ACCUM -> ignored, sample count unchanged. RST=0 during readout -> IDLE next cycle, no done pulse; a new start runs a full clean run.

Source files
------------

// File: rtl/histogram_ctrl.sv
// histogram_ctrl: sequencer for the histogram datapath. One run clears every bin,
//   accumulates n_samples input samples (one bin increment per sample), then reads
//   every bin out on the result stream. Sole master of the bin memory controls.
// Latency: CLEAR lasts MAX_NUMBER+1 cycles, ACCUM takes 1 sample per cycle at most,
//   readout is 3 cycles per bin minimum (RD_REQ, RD_WAIT, RD_OUT).
// Backpressure: s_ready is high only in ACCUM; r_valid holds r_bin/r_count stable
//   until r_ready, and no further memory read is issued while stalled.
// Ports: CLK/RST (sync, active-low); start/n_samples run request; s_valid/s_ready/
//   s_data sample stream; hist_clr/hist_inc/hist_rd/hist_addr/hist_rdata bin memory;
//   r_valid/r_ready/r_bin/r_count result stream; busy, done pulse, sticky oor.
module histogram_ctrl #(
    parameter int SIZE       = 7,
    parameter int MAX_NUMBER = 127,
    parameter int CNT_W      = 16,
    localparam int AW        = $clog2(MAX_NUMBER + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [CNT_W-1:0] n_samples,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [AW-1:0]    s_data,
    output logic             hist_clr,
    output logic             hist_inc,
    output logic             hist_rd,
    output logic [AW-1:0]    hist_addr,
    input  logic [SIZE-1:0]  hist_rdata,
    output logic             r_valid,
    input  logic             r_ready,
    output logic [AW-1:0]    r_bin,
    output logic [SIZE-1:0]  r_count,
    output logic             busy,
    output logic             done,
    output logic             oor
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CLEAR   = 3'd1;
    localparam logic [2:0] ST_ACCUM   = 3'd2;
    localparam logic [2:0] ST_RD_REQ  = 3'd3;
    localparam logic [2:0] ST_RD_WAIT = 3'd4;
    localparam logic [2:0] ST_RD_OUT  = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;

    localparam logic [AW-1:0] PTR_LAST = AW'(MAX_NUMBER);
    // One bit wider than s_data so the range test stays meaningful when
    // MAX_NUMBER is not 2^AW-1 (e.g. 99 with a 7-bit sample).
    localparam logic [AW:0]   MAX_EXT  = (AW + 1)'(MAX_NUMBER);

    logic [2:0]       state_q,   state_d;
    logic [AW-1:0]    ptr_q,     ptr_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [CNT_W-1:0] nsamp_q,   nsamp_d;
    logic [AW-1:0]    r_bin_q,   r_bin_d;
    logic [SIZE-1:0]  r_count_q, r_count_d;
    logic             oor_q,     oor_d;

    logic in_range;
    logic last_sample;

    assign in_range    = ({1'b0, s_data} <= MAX_EXT);
    // cnt_q never exceeds nsamp_q-1 in ACCUM, so the +1 cannot wrap even
    // when n_samples is all ones.
    assign last_sample = ((cnt_q + CNT_W'(1)) == nsamp_q);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        nsamp_d   = nsamp_q;
        r_bin_d   = r_bin_q;
        r_count_d = r_count_q;
        oor_d     = oor_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    nsamp_d = n_samples;
                    oor_d   = 1'b0;
                    ptr_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (ptr_q == PTR_LAST) begin
                    ptr_d   = '0;
                    cnt_d   = '0;
                    state_d = (nsamp_q == '0) ? ST_RD_REQ : ST_ACCUM;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            ST_ACCUM: begin
                if (s_valid) begin
                    if (!in_range) begin
                        oor_d = 1'b1;
                    end
                    if (last_sample) begin
                        state_d = ST_RD_REQ;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_RD_REQ: begin
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                r_count_d = hist_rdata;
                r_bin_d   = ptr_q;
                state_d   = ST_RD_OUT;
            end
            ST_RD_OUT: begin
                if (r_ready) begin
                    if (ptr_q == PTR_LAST) begin
                        ptr_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        ptr_d   = ptr_q + AW'(1);
                        state_d = ST_RD_REQ;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            nsamp_q   <= '0;
            r_bin_q   <= '0;
            r_count_q <= '0;
            oor_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            nsamp_q   <= nsamp_d;
            r_bin_q   <= r_bin_d;
            r_count_q <= r_count_d;
            oor_q     <= oor_d;
        end
    end

    // Memory controls are decoded from the state, so at most one is ever high.
    assign hist_clr = (state_q == ST_CLEAR);
    assign hist_inc = (state_q == ST_ACCUM) && s_valid && in_range;
    assign hist_rd  = (state_q == ST_RD_REQ);

    always_comb begin
        hist_addr = '0;
        if (hist_clr || hist_rd) begin
            hist_addr = ptr_q;
        end else if (hist_inc) begin
            hist_addr = s_data;
        end
    end

    assign s_ready = (state_q == ST_ACCUM);
    assign r_valid = (state_q == ST_RD_OUT);
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign oor     = oor_q;
    assign r_bin   = r_bin_q;
    assign r_count = r_count_q;

endmodule

// File: tb/tb_histogram_ctrl.sv
// tb_histogram_ctrl: directed bench for histogram_ctrl with a behavioural bin memory.
// Instance a uses MAX_NUMBER=127, instance b uses MAX_NUMBER=99 for out-of-range samples.
// Inputs change 1 time unit after the rising edge; DUT outputs are sampled on the falling edge.
module tb_histogram_ctrl;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // ---------------- instance a (MAX_NUMBER = 127) ----------------
    logic        a_start = 0, a_sv = 0, a_rr = 1;
    logic [15:0] a_n = 0;
    logic [6:0]  a_sd = 0;
    logic        a_srdy, a_clr, a_inc, a_rd, a_rv, a_busy, a_done, a_oor;
    logic [6:0]  a_addr, a_rbin, a_rcnt;
    logic [6:0]  a_rdata = 0;
    logic [6:0]  mem_a [0:127];

    histogram_ctrl #(.SIZE(7), .MAX_NUMBER(127), .CNT_W(16)) dut_a (
        .CLK(CLK), .RST(RST), .start(a_start), .n_samples(a_n),
        .s_valid(a_sv), .s_ready(a_srdy), .s_data(a_sd),
        .hist_clr(a_clr), .hist_inc(a_inc), .hist_rd(a_rd), .hist_addr(a_addr),
        .hist_rdata(a_rdata), .r_valid(a_rv), .r_ready(a_rr), .r_bin(a_rbin),
        .r_count(a_rcnt), .busy(a_busy), .done(a_done), .oor(a_oor)
    );

    always @(posedge CLK) begin
        if (a_clr) mem_a[a_addr] <= 7'd0;
        if (a_inc) mem_a[a_addr] <= mem_a[a_addr] + 7'd1;
        if (a_rd)  a_rdata <= mem_a[a_addr];
    end

    int cyc = 0;
    int a_clr_n = 0, a_clr_first = 0, a_clr_last = 0, a_clr_exp = 0, a_clr_err = 0;
    int a_inc_n = 0, a_rd_n = 0, a_done_n = 0, a_res_n = 0, a_bin_exp = 0, a_bin_err = 0;
    int a_excl_err = 0;
    logic [6:0] a_res [0:127];

    always @(negedge CLK) begin
        cyc <= cyc + 1;
        if ($countones({a_clr, a_inc, a_rd}) > 1 || (!(a_clr | a_inc | a_rd) && a_addr != 7'd0))
            a_excl_err <= a_excl_err + 1;
        if (!a_busy) begin
            a_clr_exp <= 0;
            a_bin_exp <= 0;
        end
        if (a_clr) begin
            if (a_clr_exp == 0) a_clr_first <= cyc;
            a_clr_last <= cyc;
            if (a_addr != a_clr_exp[6:0]) a_clr_err <= a_clr_err + 1;
            a_clr_exp <= a_clr_exp + 1;
            a_clr_n <= a_clr_n + 1;
        end
        if (a_inc)  a_inc_n  <= a_inc_n + 1;
        if (a_rd)   a_rd_n   <= a_rd_n + 1;
        if (a_done) a_done_n <= a_done_n + 1;
        if (a_rv && a_rr) begin
            a_res[a_rbin] <= a_rcnt;
            a_res_n <= a_res_n + 1;
            if (a_rbin != a_bin_exp[6:0]) a_bin_err <= a_bin_err + 1;
            a_bin_exp <= a_bin_exp + 1;
        end
    end

    function automatic int sum_a();
        int s = 0;
        for (int i = 0; i < 128; i++) s += int'(a_res[i]);
        return s;
    endfunction

    task automatic start_a(input int n);
        a_n = n[15:0];
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    task automatic feed_a(input int v);
        int t = 0;
        a_sv = 1'b1;
        a_sd = v[6:0];
        while (!a_srdy && t < 400) begin
            tick();
            t++;
        end
        if (t >= 400) check("a_feed_timeout", 0, 1);
        tick();
        a_sv = 1'b0;
    endtask

    task automatic run_a(input int n, input int ns, input int smp[8], input int gap[8]);
        start_a(n);
        for (int k = 0; k < ns; k++) begin
            repeat (gap[k]) tick();
            feed_a(smp[k]);
        end
    endtask

    task automatic wait_done_a();
        int d0 = a_done_n;
        int t = 0;
        while (a_done_n == d0 && t < 3000) begin
            tick();
            t++;
        end
        if (t >= 3000) check("a_done_timeout", 0, 1);
        repeat (3) tick();
    endtask

    // ---------------- instance b (MAX_NUMBER = 99) ----------------
    logic        b_start = 0, b_sv = 0, b_rr = 1;
    logic [15:0] b_n = 0;
    logic [6:0]  b_sd = 0;
    logic        b_srdy, b_clr, b_inc, b_rd, b_rv, b_busy, b_done, b_oor;
    logic [6:0]  b_addr, b_rbin, b_rcnt;
    logic [6:0]  b_rdata = 0;
    logic [6:0]  mem_b [0:127];

    histogram_ctrl #(.SIZE(7), .MAX_NUMBER(99), .CNT_W(16)) dut_b (
        .CLK(CLK), .RST(RST), .start(b_start), .n_samples(b_n),
        .s_valid(b_sv), .s_ready(b_srdy), .s_data(b_sd),
        .hist_clr(b_clr), .hist_inc(b_inc), .hist_rd(b_rd), .hist_addr(b_addr),
        .hist_rdata(b_rdata), .r_valid(b_rv), .r_ready(b_rr), .r_bin(b_rbin),
        .r_count(b_rcnt), .busy(b_busy), .done(b_done), .oor(b_oor)
    );

    always @(posedge CLK) begin
        if (b_clr) mem_b[b_addr] <= 7'd0;
        if (b_inc) mem_b[b_addr] <= mem_b[b_addr] + 7'd1;
        if (b_rd)  b_rdata <= mem_b[b_addr];
    end

    int b_acc_n = 0, b_inc_n = 0, b_done_n = 0, b_res_n = 0;
    logic [6:0] b_res [0:127];

    always @(negedge CLK) begin
        if (b_sv && b_srdy) b_acc_n <= b_acc_n + 1;
        if (b_inc)  b_inc_n  <= b_inc_n + 1;
        if (b_done) b_done_n <= b_done_n + 1;
        if (b_rv && b_rr) begin
            b_res[b_rbin] <= b_rcnt;
            b_res_n <= b_res_n + 1;
        end
    end

    function automatic int sum_b();
        int s = 0;
        for (int i = 0; i < 100; i++) s += int'(b_res[i]);
        return s;
    endfunction

    task automatic feed_b(input int v);
        int t = 0;
        b_sv = 1'b1;
        b_sd = v[6:0];
        while (!b_srdy && t < 400) begin
            tick();
            t++;
        end
        if (t >= 400) check("b_feed_timeout", 0, 1);
        tick();
        b_sv = 1'b0;
    endtask

    task automatic wait_done_b();
        int d0 = b_done_n;
        int t = 0;
        while (b_done_n == d0 && t < 3000) begin
            tick();
            t++;
        end
        if (t >= 3000) check("b_done_timeout", 0, 1);
        repeat (3) tick();
    endtask

    // ---------------- directed sequence ----------------
    int s_clr, s_inc, s_rd, s_done, s_res, s_berr, s_cerr, s_acc;
    int stable;
    int t;

    initial begin
        // Reset held for 3 cycles with start asserted.
        RST = 1'b0;
        a_start = 1'b1;
        b_start = 1'b1;
        repeat (3) tick();
        @(negedge CLK);
        check("rst_busy", a_busy, 0);
        check("rst_s_ready", a_srdy, 0);
        check("rst_r_valid", a_rv, 0);
        check("rst_done", a_done, 0);
        check("rst_oor", a_oor, 0);
        check("rst_hist_ctl", {a_clr, a_inc, a_rd, a_addr}, 0);
        check("rst_b_busy", b_busy, 0);
        a_start = 1'b0;
        b_start = 1'b0;
        tick();
        RST = 1'b1;
        repeat (3) tick();
        check("idle_after_rst", a_busy, 0);

        // Clear sweep with n_samples = 0.
        s_clr = a_clr_n; s_inc = a_inc_n; s_done = a_done_n; s_res = a_res_n;
        s_berr = a_bin_err; s_cerr = a_clr_err;
        run_a(0, 0, '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
        wait_done_a();
        check("clr_cycles", a_clr_n - s_clr, 128);
        check("clr_contiguous", a_clr_last - a_clr_first, 127);
        check("clr_addr_order", a_clr_err - s_cerr, 0);
        check("clr_no_inc", a_inc_n - s_inc, 0);
        check("clr_results", a_res_n - s_res, 128);
        check("clr_bin_order", a_bin_err - s_berr, 0);
        check("clr_sum_zero", sum_a(), 0);
        check("clr_done_pulses", a_done_n - s_done, 1);

        // Accumulate 3,3,10,127,3 with valid gaps.
        s_inc = a_inc_n; s_done = a_done_n; s_res = a_res_n;
        run_a(5, 5, '{3, 3, 10, 127, 3, 0, 0, 0}, '{0, 2, 1, 3, 0, 0, 0, 0});
        wait_done_a();
        check("acc_inc", a_inc_n - s_inc, 5);
        check("acc_bin3", a_res[3], 3);
        check("acc_bin10", a_res[10], 1);
        check("acc_bin127", a_res[127], 1);
        check("acc_sum", sum_a(), 5);
        check("acc_results", a_res_n - s_res, 128);
        check("acc_oor", a_oor, 0);
        check("acc_done_pulses", a_done_n - s_done, 1);

        // Backpressure on bin 10.
        s_res = a_res_n; s_berr = a_bin_err;
        run_a(1, 1, '{10, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
        t = 0;
        while (!(a_rv && a_rbin == 7'd10) && t < 2000) begin
            tick();
            t++;
        end
        if (t >= 2000) check("bp_reach_timeout", 0, 1);
        a_rr = 1'b0;
        s_rd = a_rd_n;
        stable = 0;
        repeat (10) begin
            @(negedge CLK);
            if (a_rv && a_rbin == 7'd10 && a_rcnt == 7'd1) stable++;
            tick();
        end
        check("bp_stable_cycles", stable, 10);
        check("bp_no_rd", a_rd_n - s_rd, 0);
        a_rr = 1'b1;
        wait_done_a();
        check("bp_bin10", a_res[10], 1);
        check("bp_results", a_res_n - s_res, 128);
        check("bp_bin_order", a_bin_err - s_berr, 0);
        check("excl_addr", a_excl_err, 0);

        // Out-of-range samples on the MAX_NUMBER = 99 instance.
        s_acc = b_acc_n; s_inc = b_inc_n; s_res = b_res_n;
        b_n = 16'd3;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        feed_b(5);
        tick();
        feed_b(120);
        tick();
        feed_b(5);
        wait_done_b();
        check("oor_accepted", b_acc_n - s_acc, 3);
        check("oor_incs", b_inc_n - s_inc, 2);
        check("oor_bin5", b_res[5], 2);
        check("oor_sum", sum_b(), 2);
        check("oor_results", b_res_n - s_res, 100);
        check("oor_flag_end", b_oor, 1);
        repeat (5) tick();
        check("oor_flag_held", b_oor, 1);
        b_n = 16'd0;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        tick();
        check("oor_cleared_on_start", b_oor, 0);
        wait_done_b();

        // Start while busy is ignored; reset during readout abandons the run.
        s_inc = a_inc_n; s_done = a_done_n; s_res = a_res_n;
        start_a(3);
        feed_a(7);
        a_n = 16'd1;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        check("busy_start_sready1", a_srdy, 1);
        feed_a(7);
        check("busy_start_sready2", a_srdy, 1);
        feed_a(7);
        check("accum_ends", a_srdy, 0);
        check("busy_start_incs", a_inc_n - s_inc, 3);
        t = 0;
        while (a_res_n - s_res < 20 && t < 2000) begin
            tick();
            t++;
        end
        if (t >= 2000) check("mid_reset_timeout", 0, 1);
        RST = 1'b0;
        tick();
        RST = 1'b1;
        check("mid_reset_busy", a_busy, 0);
        check("mid_reset_rvalid", a_rv, 0);
        repeat (200) tick();
        check("mid_reset_no_done", a_done_n - s_done, 0);

        s_done = a_done_n; s_res = a_res_n;
        run_a(0, 0, '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
        wait_done_a();
        check("rerun_results", a_res_n - s_res, 128);
        check("rerun_sum_zero", sum_a(), 0);
        check("rerun_done", a_done_n - s_done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
